a_tile_feeder: RTL and testbench

Tile buffer and column sequencer directly upstream of the A-operand skew stage (`DataReOrganize`). It accepts one A tile column-by-column from the operand loader and stores it. It then replays the tile as `tile_cols` consecutive column vectors on a registered bus with an enable strobe, which drives the skew stage's `din`/`en`. After the last column it appends `a_tile_column_size` all-zero columns so the skew pipeline fully drains the last column to its output.

---
 rtl/a_tile_feeder.sv | 183 ++++++++++++++++++
 tb/tb_a_tile_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_tile_feeder.sv
// a_tile_feeder
//   Tile buffer and column sequencer feeding the A-operand skew stage.
//   Captures one A tile column-by-column, then replays it as tile_cols
//   registered column beats followed by a_tile_column_size all-zero beats.
//   The zero beats let the skew pipeline drain the last real column.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   wr_valid   in   upstream column valid
//   wr_ready   out  feeder can accept a column (combinational)
//   wr_data    in   column, element r at [data_width*(r+1)-1 : data_width*r]
//   hold       in   downstream stall, freezes STREAM/FLUSH
//   dout_en    out  registered beat strobe (skew-stage en)
//   dout       out  registered column (skew-stage din)
//   tile_first out  registered, marks the column-0 beat
//   tile_last  out  registered, marks the final flush beat
//   busy       out  registered, high in STREAM or FLUSH
//
// Build option
//   A_FEEDER_PINGPONG_EN : two banks so the next tile can load while the
//   current one streams. Undefined: one bank, writes only in LOAD.
//
// state  | meaning
// -------+--------------------------------------------------------------
// LOAD   | waiting for a complete tile (or, with two banks, a full bank)
// STREAM | replaying stored columns 0..tile_cols-1
// FLUSH  | emitting a_tile_column_size zero columns to drain the skew

module a_tile_feeder #(
  parameter int data_width         = 20,
  parameter int a_tile_column_size = 6,
  parameter int tile_cols          = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic [data_width*a_tile_column_size-1:0] wr_data,
  input  logic                                     hold,
  output logic                                     dout_en,
  output logic [data_width*a_tile_column_size-1:0] dout,
  output logic                                     tile_first,
  output logic                                     tile_last,
  output logic                                     busy
);

  localparam int col_w = data_width * a_tile_column_size;
  localparam int cw    = (tile_cols > 1) ? $clog2(tile_cols) : 1;
  localparam int fw    = (a_tile_column_size > 1) ? $clog2(a_tile_column_size) : 1;
  localparam logic [cw-1:0] wc_last = cw'(tile_cols - 1);
  localparam logic [fw-1:0] fc_last = fw'(a_tile_column_size - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [cw-1:0]    wc, rc;
  logic [fw-1:0]    fc;
  logic [col_w-1:0] rd_col;
  logic             wr_fire, load_done;
  logic             stream_beat, flush_beat, flush_done;
  logic             start_ok, chain_ok;

`ifdef A_FEEDER_PINGPONG_EN
  logic             wb, rb;
  logic [1:0]       full;
  logic [col_w-1:0] mem [2][tile_cols];

  // Start from idle when the read bank is full or is being completed now.
  assign start_ok = full[rb] || (load_done && (wb == rb));
  // At end of flush, continue straight into the other bank if it is ready.
  assign chain_ok = full[~rb] || (load_done && (wb != rb));
  assign rd_col   = mem[rb][rc];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wb][wc] <= wr_data;
  end

  // Fill and release may land on the same edge; they always touch
  // different banks because a full write bank blocks wr_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb   <= 1'b0;
      rb   <= 1'b0;
      full <= '0;
    end else begin
      if (load_done) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
      if (flush_done) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end
`else
  logic [col_w-1:0] mem [tile_cols];

  assign start_ok = load_done;
  assign chain_ok = 1'b0;
  assign rd_col   = mem[rc];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wc] <= wr_data;
  end
`endif

  // Gating with rst keeps the unreset buffer from capturing during reset.
  assign wr_fire   = wr_valid && wr_ready && !rst;
  assign load_done = wr_fire && (wc == wc_last);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (start_ok) state_nxt = STREAM;
      STREAM:  if (stream_beat && (rc == wc_last)) state_nxt = FLUSH;
      FLUSH:   if (flush_done) state_nxt = chain_ok ? STREAM : LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output / control decode
  always_comb begin
`ifdef A_FEEDER_PINGPONG_EN
    wr_ready = !full[wb];
`else
    wr_ready = (state == LOAD);
`endif
    stream_beat = (state == STREAM) && !hold;
    flush_beat  = (state == FLUSH) && !hold;
    flush_done  = flush_beat && (fc == fc_last);
  end

  // Counters and registered outputs. Strobes default low so any edge that
  // is not a beat (LOAD, or hold) clears them while dout keeps its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc         <= '0;
      rc         <= '0;
      fc         <= '0;
      dout       <= '0;
      dout_en    <= 1'b0;
      tile_first <= 1'b0;
      tile_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_en    <= 1'b0;
      tile_first <= 1'b0;
      tile_last  <= 1'b0;
      busy       <= (state_nxt != LOAD);

      if (wr_fire) wc <= (wc == wc_last) ? '0 : wc + 1'b1;

      if (stream_beat) begin
        dout       <= rd_col;
        dout_en    <= 1'b1;
        tile_first <= (rc == '0);
        rc         <= (rc == wc_last) ? '0 : rc + 1'b1;
      end

      if (flush_beat) begin
        dout      <= '0;
        dout_en   <= 1'b1;
        tile_last <= (fc == fc_last);
        fc        <= (fc == fc_last) ? '0 : fc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_a_tile_feeder.sv
module tb_a_tile_feeder;

  localparam int DW = 20;
  localparam int CS = 6;
  localparam int TC = 8;
  localparam int W  = DW * CS;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_data;
  logic         hold;
  logic         dout_en;
  logic [W-1:0] dout;
  logic         tile_first;
  logic         tile_last;
  logic         busy;

  a_tile_feeder #(
    .data_width(DW),
    .a_tile_column_size(CS),
    .tile_cols(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .hold(hold),
    .dout_en(dout_en),
    .dout(dout),
    .tile_first(tile_first),
    .tile_last(tile_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A tile is a list of columns; once complete it waits in pend, and when the
  // output is idle it becomes a list of expected beats (columns then zeros).
  typedef struct {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } beat_t;

  logic [W-1:0] wtile[$];
  logic [W-1:0] pend[$];
  beat_t        beats[$];
  logic [W-1:0] exp_dout;
  logic         exp_en, exp_first, exp_last, exp_busy;

  function automatic void model_reset();
    wtile.delete();
    pend.delete();
    beats.delete();
    exp_dout  = '0;
    exp_en    = 1'b0;
    exp_first = 1'b0;
    exp_last  = 1'b0;
    exp_busy  = 1'b0;
  endfunction

  function automatic logic model_ready();
`ifdef A_FEEDER_PINGPONG_EN
    int stored;
    stored = pend.size() / TC + ((beats.size() > 0) ? 1 : 0);
    return stored < 2;
`else
    return beats.size() == 0;
`endif
  endfunction

  // Called at posedge+1; applies inputs, samples across one edge, checks.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic h);
    logic  ready_m;
    logic  fire;
    beat_t b;
    wr_valid = v;
    wr_data  = d;
    hold     = h;
    #1;
    ready_m = model_ready();
    chk1("wr_ready", wr_ready, ready_m);
    fire = v && ready_m;
    if (beats.size() > 0 && !h) begin
      b         = beats.pop_front();
      exp_en    = 1'b1;
      exp_dout  = b.d;
      exp_first = b.f;
      exp_last  = b.l;
    end else begin
      exp_en    = 1'b0;
      exp_first = 1'b0;
      exp_last  = 1'b0;
    end
    if (fire) begin
      wtile.push_back(d);
      if (wtile.size() == TC) begin
        foreach (wtile[i]) pend.push_back(wtile[i]);
        wtile.delete();
      end
    end
    if (beats.size() == 0 && pend.size() >= TC) begin
      for (int c = 0; c < TC; c++) begin
        b.d = pend.pop_front();
        b.f = (c == 0);
        b.l = 1'b0;
        beats.push_back(b);
      end
      for (int f = 0; f < CS; f++) begin
        b.d = '0;
        b.f = 1'b0;
        b.l = (f == CS - 1);
        beats.push_back(b);
      end
    end
    exp_busy = (beats.size() > 0);
    @(posedge clk);
    #1;
    chk1("dout_en", dout_en, exp_en);
    chk("dout", dout, exp_dout);
    chk1("tile_first", tile_first, exp_first);
    chk1("tile_last", tile_last, exp_last);
    chk1("busy", busy, exp_busy);
  endtask

  function automatic logic [W-1:0] pat(input int s, input int c);
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < CS; r++) v[DW*r +: DW] = DW'(16 * c + r + 256 * s);
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_col();
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom};
    return x[W-1:0];
  endfunction

  task automatic write_tile(input int s);
    for (int c = 0; c < TC; c++) cycle(1'b1, pat(s, c), 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    hold = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic hold;
    logic en;
    logic first;
    logic last;
    int   col;   // -1 = zero column
  } vec_t;

  function automatic vec_t mk(input logic h, input logic e, input logic f, input logic l, input int c);
    vec_t v;
    v.hold = h; v.en = e; v.first = f; v.last = l; v.col = c;
    return v;
  endfunction

  vec_t tbl[32];

  initial begin
    int k;
    int lasts;
    logic prev_last;

    // Entries 0..13: single tile, no hold. Entries 14..31: same tile
    // shape with hold over beats 3-5 and over flush beat 2.
    for (int i = 0; i < TC + CS; i++)
      tbl[i] = mk(1'b0, 1'b1, i == 0, i == TC + CS - 1, (i < TC) ? i : -1);
    k = 14;
    tbl[k++] = mk(0, 1, 1, 0, 0);
    tbl[k++] = mk(0, 1, 0, 0, 1);
    tbl[k++] = mk(0, 1, 0, 0, 2);
    tbl[k++] = mk(1, 0, 0, 0, 2);
    tbl[k++] = mk(1, 0, 0, 0, 2);
    tbl[k++] = mk(1, 0, 0, 0, 2);
    for (int c = 3; c < TC; c++) tbl[k++] = mk(0, 1, 0, 0, c);
    tbl[k++] = mk(0, 1, 0, 0, -1);
    tbl[k++] = mk(0, 1, 0, 0, -1);
    tbl[k++] = mk(1, 0, 0, 0, -1);
    tbl[k++] = mk(0, 1, 0, 0, -1);
    tbl[k++] = mk(0, 1, 0, 0, -1);
    tbl[k++] = mk(0, 1, 0, 0, -1);
    tbl[k++] = mk(0, 1, 0, 1, -1);

    // Reset state; a write offered during reset must not be taken.
    rst = 1'b1;
    wr_valid = 1'b0;
    hold = 1'b0;
    wr_data = '0;
    model_reset();
    #2;
    chk1("rst_wr_ready", wr_ready, 1'b1);
    chk1("rst_dout_en", dout_en, 1'b0);
    chk("rst_dout", dout, '0);
    chk1("rst_tile_first", tile_first, 1'b0);
    chk1("rst_tile_last", tile_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    wr_valid = 1'b1;
    wr_data = rnd_col();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b0;

    // Table: single tile, then held tile.
    write_tile(0);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, '0, tbl[i].hold);
      chk1("tbl_en", dout_en, tbl[i].en);
      chk1("tbl_first", tile_first, tbl[i].first);
      chk1("tbl_last", tile_last, tbl[i].last);
      chk("tbl_dout", dout, (tbl[i].col >= 0) ? pat(0, tbl[i].col) : '0);
    end
    write_tile(1);
    for (int i = 14; i < 32; i++) begin
      cycle(1'b0, '0, tbl[i].hold);
      chk1("tbl_hold_en", dout_en, tbl[i].en);
      chk1("tbl_hold_first", tile_first, tbl[i].first);
      chk1("tbl_hold_last", tile_last, tbl[i].last);
      chk("tbl_hold_dout", dout, (tbl[i].col >= 0) ? pat(1, tbl[i].col) : '0);
    end
    cycle(1'b0, '0, 1'b0);

    // Lane mapping: element r = r+1 in every column.
    begin
      logic [W-1:0] lane_col;
      lane_col = '0;
      for (int r = 0; r < CS; r++) lane_col[DW*r +: DW] = DW'(r + 1);
      for (int c = 0; c < TC; c++) cycle(1'b1, lane_col, 1'b0);
      for (int i = 0; i < TC + CS; i++) begin
        cycle(1'b0, '0, 1'b0);
        if (i < TC)
          for (int r = 0; r < CS; r++) chk("lane", W'(dout[DW*r +: DW]), W'(r + 1));
      end
    end

    // Reset in the middle of STREAM, after beat 4 has been emitted.
    write_tile(2);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
    chk("pre_rst_beat4", dout, pat(2, 4));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk1("mid_rst_dout_en", dout_en, 1'b0);
    chk("mid_rst_dout", dout, '0);
    chk1("mid_rst_first", tile_first, 1'b0);
    chk1("mid_rst_last", tile_last, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_data = rnd_col();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    write_tile(3);
    for (int i = 0; i < TC + CS; i++) cycle(1'b0, '0, 1'b0);

    // Backpressure: wr_valid held high across two tiles.
    for (int i = 0; i < 2 * (2 * TC + CS) + 4; i++) cycle(1'b1, rnd_col(), 1'b0);
    do_reset();

`ifdef A_FEEDER_PINGPONG_EN
    // Tile 5 loads while tile 4 streams; it must follow tile 4 with no gap.
    lasts = 0;
    prev_last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(i < 2 * TC, (i < TC) ? pat(4, i) : pat(5, i - TC), 1'b0);
      if (i == 2 * TC - 1) chk1("pp_both_full_ready", wr_ready, 1'b0);
      if (prev_last && lasts == 1) begin
        chk1("pp_chain_en", dout_en, 1'b1);
        chk1("pp_chain_first", tile_first, 1'b1);
        chk("pp_chain_col0", dout, pat(5, 0));
      end
      if (tile_last) lasts++;
      prev_last = tile_last;
    end
    chk("pp_tiles_done", W'(lasts), W'(2));
    do_reset();
`else
    lasts = 0;
    prev_last = 1'b0;
`endif

    // Randomised traffic with random hold.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, rnd_col(), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 2 * (TC + CS) + 4; i++) cycle(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
